adder_seq_ctrl: RTL and testbench
=================================

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter WORDS, default 4, number of 32-bit words per operand (legal 2..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; accepted only on an edge where ready=1.
REQ-005 sub  input  1  0 = a+b+cin, 1 = a-b (two's complement).
REQ-006 a  input  32*WORDS  operand 1, word 0 = bits [31:0].
REQ-007 b  input  32*WORDS  operand 2.
REQ-008 cin  input  1  initial carry-in for add; ignored when sub=1.
REQ-009 ready  output  1  high in IDLE only.
REQ-010 done  output  1  one-cycle pulse, result/cout valid.
REQ-011 result  output  32*WORDS  registered result, held until next accept.
REQ-012 cout  output  1  final carry-out (add) / no-borrow flag (sub).
REQ-013 add_op1  output  32  to shared 32-bit lookahead adder op1.
REQ-014 add_op2  output  32  to adder op2.
REQ-015 add_cin  output  1  to adder cin.
REQ-016 add_sum  input  32  from adder sum (combinational path).
REQ-017 add_cout  input  1  from adder cout.

Function
REQ-018 States IDLE, RUN, DONE; IDLE->RUN on accept, RUN->DONE after word WORDS-1, DONE->IDLE unconditionally next edge.
REQ-019 Accept edge: latch a, b (b bitwise-inverted when sub=1), carry_r <= (sub ? 1 : cin), idx <= 0, state <= RUN.
REQ-020 RUN, each cycle: add_op1 = a_r word idx, add_op2 = b_r word idx, add_cin = carry_r; all combinational from registers.
REQ-021 RUN, each edge: result word idx <= add_sum, carry_r <= add_cout, idx <= idx+1.
REQ-022 Edge with idx=WORDS-1 in RUN: cout <= add_cout, state <= DONE.
REQ-023 done = 1 exactly during DONE cycle; DONE cycle begins WORDS+1 edges after accept edge.
REQ-024 Outside RUN, add_op1=0, add_op2=0, add_cin=0.
REQ-025 start while ready=0 (RUN or DONE) ignored; no queueing; a/b changes after accept have no effect.
REQ-026 result and cout retain value through IDLE until overwritten word-by-word by next operation; result words not yet processed keep previous values during RUN.
REQ-027 Adder latency assumed purely combinational within one cycle; no other arithmetic performed in this block.
REQ-028 idx width ceil(log2(WORDS)) bits; no wrap past WORDS-1.

Reset
REQ-029 rst_n low: immediately state=IDLE, idx=0, carry_r=0, a_r=b_r=0, result=0, cout=0, done=0, ready=1, adder outputs 0.
REQ-030 rst_n asserted mid-RUN or in DONE aborts the operation; no done pulse is produced for it.
REQ-031 First accept possible on the first rising edge with rst_n high and start high.

Verification (WORDS=4)
REQ-032 a=all ones (128-bit), b=1, cin=0, sub=0 -> result=0, cout=1, done exactly 5 edges after accept, ready low 5 cycles.
REQ-033 a=0x00000000_00000000_00000000_FFFFFFFF, b=1 -> result=0x00000000_00000000_00000001_00000000, cout=0; add_cin=1 observed in word-1 cycle.
REQ-034 each word a=0xFFFF0000, b=0x0000FFFF, cin=1 -> result=0, cout=1; add_cin=1 in all four RUN cycles.
REQ-035 sub=1, a=5, b=7 -> result=0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, cout=0; a=7, b=5 -> result=2, cout=1.
REQ-036 start held high continuously -> operations accepted only in IDLE, one accept per 6 cycles, changed a/b mid-RUN not reflected in result.
REQ-037 rst_n pulsed low in second RUN cycle -> result=0, ready=1 immediately, no done pulse; subsequent operation completes correctly.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl
// Multi-word add/subtract sequencer. Operands of WORDS x 32 bits are pushed
// one word per cycle through an external shared 32-bit adder, least
// significant word first, with the carry rippled between words in carry_reg.
// Subtraction is done as a + ~b + 1, so cout reads as "no borrow".

module adder_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [32*WORDS-1:0]   a,
  input  logic [32*WORDS-1:0]   b,
  input  logic                  cin,
  output logic                  ready,
  output logic                  done,
  output logic [32*WORDS-1:0]   result,
  output logic                  cout,
  output logic [31:0]           add_op1,
  output logic [31:0]           add_op2,
  output logic                  add_cin,
  input  logic [31:0]           add_sum,
  input  logic                  add_cout
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [IDXW-1:0]         idx_reg;
  logic                    carry_reg;
  logic [32*WORDS-1:0]     a_reg;
  logic [32*WORDS-1:0]     b_reg;
  logic [WORDS-1:0][31:0]  result_reg;
  logic                    cout_reg;

  logic                    accept;
  logic                    last_word;
  logic                    running;
  logic [31:0]             a_word [WORDS];
  logic [31:0]             b_word [WORDS];

  // Split the latched operands into 32-bit words for the per-cycle mux.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
      assign a_word[gi] = a_reg[gi*32 +: 32];
      assign b_word[gi] = b_reg[gi*32 +: 32];
      assign result[gi*32 +: 32] = result_reg[gi];
    end
  endgenerate

  assign running   = (state_reg == RUN);
  assign last_word = (idx_reg == LAST_IDX);
  assign accept    = (state_reg == IDLE) && start;
  assign cout      = cout_reg;

  // State register; async reset returns to IDLE at once and aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus all state-decoded outputs; the adder ports idle at zero.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    done       = 1'b0;
    add_op1    = 32'd0;
    add_op2    = 32'd0;
    add_cin    = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        add_op1 = a_word[idx_reg];
        add_op2 = b_word[idx_reg];
        add_cin = carry_reg;
        if (last_word) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture on accept and carry/index stepping while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
    end else if (accept) begin
      a_reg     <= a;
      // Subtraction as a + ~b + 1: invert b here, seed the carry with 1.
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub | cin;
      idx_reg   <= '0;
    end else if (running) begin
      carry_reg <= add_cout;
      // Hold on the last word so the index never wraps past WORDS-1.
      if (!last_word) begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  // Result words are overwritten one at a time; untouched words keep old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
    end else if (running) begin
      result_reg[idx_reg] <= add_sum;
    end
  end

  // Final carry/no-borrow flag taken from the adder on the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_reg <= 1'b0;
    end else if (running && last_word) begin
      cout_reg <= add_cout;
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl (WORDS=4): directed vectors plus random operations
// checked against a wide-arithmetic reference model; the shared 32-bit adder
// is modelled here as plain combinational arithmetic.

module tb_adder_seq_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          sub = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          ready;
  logic          done;
  logic [W-1:0]  result;
  logic          cout;
  logic [31:0]   add_op1;
  logic [31:0]   add_op2;
  logic          add_cin;
  logic [31:0]   add_sum;
  logic          add_cout;

  int checks = 0;
  int errors = 0;

  adder_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .add_op1  (add_op1),
    .add_op2  (add_op2),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // External shared adder.
  assign {add_cout, add_sum} = {1'b0, add_op1} + {1'b0, add_op2} + 33'(add_cin);

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: {carry/no-borrow, result} of the full-width operation.
  function automatic logic [W:0] ref_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                                        input logic sv, input logic cv);
    if (sv) return {(av >= bv), av - bv};
    return {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
  endfunction

  // Drives one operation from IDLE and checks its whole protocol on the way.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input logic cv, input string tag, output logic [WORDS-1:0] cin_seen);
    logic [W:0]   exp;
    logic [W-1:0] be;
    logic [W-1:0] mask;
    logic [W:0]   lo;
    int edges;
    int lowc;
    int k;
    exp = ref_op(av, bv, sv, cv);
    be = sv ? ~bv : bv;
    cin_seen = '0;
    checks++;
    if (ready !== 1'b1 || add_op1 !== 32'd0 || add_op2 !== 32'd0 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: ready=%b op1=%h op2=%h cin=%b, required ready=1 and adder inputs 0",
               tag, ready, add_op1, add_op2, add_cin);
    end
    a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    a = rand_wide(); b = rand_wide(); sub = 1'($urandom); cin = 1'($urandom);
    k = 0;
    lowc = 0;
    while (done !== 1'b1 && edges < 20) begin
      if (ready === 1'b0) lowc++;
      if (k < WORDS) begin
        mask = (W'(1) << (32*k)) - W'(1);
        lo = {1'b0, av & mask} + {1'b0, be & mask} + (W+1)'(sv ? 1'b1 : cv);
        cin_seen[k] = add_cin;
        checks++;
        if (add_op1 !== av[32*k +: 32] || add_op2 !== be[32*k +: 32] || add_cin !== lo[32*k]) begin
          errors++;
          $display("FAIL %s_word%0d: op1=%h op2=%h cin=%b, required op1=%h op2=%h cin=%b",
                   tag, k, add_op1, add_op2, add_cin, av[32*k +: 32], be[32*k +: 32], lo[32*k]);
        end
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
      k++;
    end
    if (ready === 1'b0) lowc++;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done=%b after %0d edges, required a done pulse", tag, done, edges);
    end else begin
      checks++;
      if (edges != WORDS + 1) begin
        errors++;
        $display("FAIL %s_latency: done after %0d edges, required %0d", tag, edges, WORDS + 1);
      end
      checks++;
      if (lowc != WORDS + 1) begin
        errors++;
        $display("FAIL %s_ready_low: ready low %0d cycles, required %0d", tag, lowc, WORDS + 1);
      end
      checks++;
      if ({cout, result} !== exp) begin
        errors++;
        $display("FAIL %s_result: cout=%b result=%h, required cout=%b result=%h",
                 tag, cout, result, exp[W], exp[W-1:0]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || {cout, result} !== exp) begin
      errors++;
      $display("FAIL %s_after: done=%b ready=%b result=%h, required done=0 ready=1 result held %h",
               tag, done, ready, result, exp[W-1:0]);
    end
    $display("op %s a=%h b=%h sub=%b cin=%b -> result=%h cout=%b", tag, av, bv, sv, cv, result, cout);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b done=%b, required 1/0", ready, done);
    end
    checks++;
    if (result !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: result=%h cout=%b, required 0/0", result, cout);
    end
    checks++;
    if (add_op1 !== 32'd0 || add_op2 !== 32'd0 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_adder: op1=%h op2=%h cin=%b, required 0", add_op1, add_op2, add_cin);
    end
    start = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b done=%b with start high in reset, required 1/0", ready, done);
    end
    start = 1'b0;
    rst_n = 1'b1;
    $display("reset released ready=%b done=%b result=%h", ready, done, result);
  endtask

  task automatic test_vectors();
    logic [WORDS-1:0] cs;
    // First operation right after reset release also covers the first-edge accept.
    run_op({W{1'b1}}, W'(1), 1'b0, 1'b0, "allones_plus1", cs);
    checks++;
    if (result !== '0 || cout !== 1'b1) begin
      errors++;
      $display("FAIL allones_const: result=%h cout=%b, required 0/1", result, cout);
    end
    run_op(W'(32'hFFFF_FFFF), W'(1), 1'b0, 1'b0, "word_carry", cs);
    checks++;
    if (result !== (W'(1) << 32) || cout !== 1'b0 || cs[1] !== 1'b1) begin
      errors++;
      $display("FAIL word_carry_const: result=%h cout=%b cin_w1=%b, required %h/0/1",
               result, cout, cs[1], W'(1) << 32);
    end
    run_op({WORDS{32'hFFFF_0000}}, {WORDS{32'h0000_FFFF}}, 1'b0, 1'b1, "cin_chain", cs);
    checks++;
    if (result !== '0 || cout !== 1'b1 || cs !== {WORDS{1'b1}}) begin
      errors++;
      $display("FAIL cin_chain_const: result=%h cout=%b cins=%b, required 0/1/1111", result, cout, cs);
    end
    run_op(W'(5), W'(7), 1'b1, 1'b0, "sub_neg", cs);
    checks++;
    if (result !== ~W'(1) || cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg_const: result=%h cout=%b, required %h/0", result, cout, ~W'(1));
    end
    run_op(W'(7), W'(5), 1'b1, 1'b1, "sub_pos", cs);
    checks++;
    if (result !== W'(2) || cout !== 1'b1) begin
      errors++;
      $display("FAIL sub_pos_const: result=%h cout=%b, required 2/1", result, cout);
    end
  endtask

  task automatic test_random();
    logic [WORDS-1:0] cs;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    for (int i = 0; i < 25; i++) begin
      av = rand_wide();
      bv = (i % 5 == 0) ? av : rand_wide();
      run_op(av, bv, 1'($urandom), 1'($urandom), "random", cs);
    end
  endtask

  task automatic test_start_held();
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    logic [W:0]   exp;
    int acc_cyc [3];
    int n_acc = 0;
    int n_done = 0;
    int cyc = 0;
    for (int i = 0; i < 3; i++) begin
      pa[i] = rand_wide();
      pb[i] = rand_wide();
      acc_cyc[i] = -100;
    end
    sub = 1'b0; cin = 1'b0; start = 1'b1;
    for (int t = 0; t < 40 && n_done < 3; t++) begin
      if (ready === 1'b1 && n_acc < 3) begin
        a = pa[n_acc]; b = pb[n_acc];
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end else begin
        a = rand_wide(); b = rand_wide();
      end
      if (done === 1'b1) begin
        exp = ref_op(pa[n_done], pb[n_done], 1'b0, 1'b0);
        checks++;
        if ({cout, result} !== exp) begin
          errors++;
          $display("FAIL held_result%0d: cout=%b result=%h, required cout=%b result=%h",
                   n_done, cout, result, exp[W], exp[W-1:0]);
        end
        $display("held op%0d accepted at cycle %0d -> result=%h cout=%b", n_done, acc_cyc[n_done], result, cout);
        n_done++;
        if (n_done == 3) start = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (n_done != 3) begin
      errors++;
      $display("FAIL held_count: %0d operations completed, required 3", n_done);
    end
    checks++;
    if (acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6) begin
      errors++;
      $display("FAIL held_spacing: accepts at cycles %0d %0d %0d, required spacing 6",
               acc_cyc[0], acc_cyc[1], acc_cyc[2]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [WORDS-1:0] cs;
    int pulses = 0;
    a = rand_wide(); b = rand_wide(); sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: ready=%b done=%b result=%h cout=%b, required 1/0/0/0",
               ready, done, result, cout);
    end
    checks++;
    if (add_op1 !== 32'd0 || add_op2 !== 32'd0 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL midrun_adder: op1=%h op2=%h cin=%b, required 0", add_op1, add_op2, add_cin);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midrun_done: %0d done pulses after abort, required 0", pulses);
    end
    $display("midrun reset: ready=%b result=%h done pulses=%0d", ready, result, pulses);
    run_op(rand_wide(), rand_wide(), 1'b1, 1'b0, "after_abort", cs);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_start_held();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
